// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared combinational ALU.
// One operation is in flight at a time: IDLE (arbitrate/accept) -> EXEC (ALU
// evaluates registered operands) -> RESP (result held until its owner takes it).
module alu_arbiter #(
   parameter logic LAST_INIT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        r0_valid,
   output logic        r0_ready,
   input  logic [3:0]  r0_sel,
   input  logic [31:0] r0_a,
   input  logic [31:0] r0_b,
   input  logic        r0_rsp_ready,
   input  logic        r1_valid,
   output logic        r1_ready,
   input  logic [3:0]  r1_sel,
   input  logic [31:0] r1_a,
   input  logic [31:0] r1_b,
   input  logic        r1_rsp_ready,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_sel,
   input  logic [31:0] alu_out,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_last;
   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_acc;
   logic        w_acc_id;
   logic        w_rsp_acc;

   logic [31:0] r_alu_a;
   logic [31:0] r_alu_b;
   logic [3:0]  r_alu_sel;
   logic        r_rsp_valid;
   logic        r_rsp_id;
   logic [31:0] r_rsp_data;
   logic        r_rsp_err;

   // Select codes 1010..1101 are reported as unsupported operations.
   function automatic logic sel_is_err(input logic [3:0] sel);
      return (sel >= 4'b1010) && (sel <= 4'b1101);
   endfunction

   // Compare codes only define bit 0; unsupported codes yield zero.
   function automatic logic [31:0] shape_result(input logic [3:0] sel,
                                                input logic [31:0] raw);
      logic [31:0] res;
      res = raw;
      if ((sel == 4'b1000) || (sel == 4'b1001)) begin
         res = {31'b0, raw[0]};
      end else if (sel_is_err(sel)) begin
         res = 32'h0;
      end
      return res;
   endfunction

   // Next-state, grant and response-accept decode.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_rsp_acc   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!rst) begin
               // On a tie the requester that did not win last time is served.
               w_gnt0 = r0_valid && (!r1_valid || r_last);
               w_gnt1 = r1_valid && (!r0_valid || !r_last);
            end
            if (w_gnt0 || w_gnt1) begin
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            // Only the owner of the response can release it.
            w_rsp_acc = r_rsp_id ? r1_rsp_ready : r0_rsp_ready;
            if (w_rsp_acc) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_acc    = w_gnt0 || w_gnt1;
   assign w_acc_id = w_gnt1;

   // State register and last-granted pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_last  <= LAST_INIT;
      end else begin
         r_state <= w_state_nxt;
         if (w_acc) begin
            r_last <= w_acc_id;
         end
      end
   end

   // Operand capture on accept, result capture at the end of EXEC.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_sel   <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         if (w_acc) begin
            r_alu_a   <= w_acc_id ? r1_a   : r0_a;
            r_alu_b   <= w_acc_id ? r1_b   : r0_b;
            r_alu_sel <= w_acc_id ? r1_sel : r0_sel;
            r_rsp_id  <= w_acc_id;
         end
         if (r_state == S_EXEC) begin
            r_rsp_data  <= shape_result(r_alu_sel, alu_out);
            r_rsp_err   <= sel_is_err(r_alu_sel);
            r_rsp_valid <= 1'b1;
         end else if (w_rsp_acc) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign r0_ready  = w_gnt0;
   assign r1_ready  = w_gnt1;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_sel   = r_alu_sel;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: models the shared ALU (with junk upper bits on compare
// codes and junk on unsupported codes), runs fixed vectors, arbitration and
// reset sequences, and randomized traffic against a request-level model.
module tb_alu_arbiter;

   logic        clk;
   logic        rst;
   logic        r0_valid, r0_ready, r0_rsp_ready;
   logic        r1_valid, r1_ready, r1_rsp_ready;
   logic [3:0]  r0_sel, r1_sel;
   logic [31:0] r0_a, r0_b, r1_a, r1_b;
   logic        rsp_valid, rsp_id, rsp_err, busy;
   logic [31:0] rsp_data, alu_a, alu_b, alu_out;
   logic [3:0]  alu_sel;

   logic [31:0] garb;
   int          checks;
   int          failures;
   bit          m_last;

   alu_arbiter #(.LAST_INIT(1'b1)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_sel(r0_sel),
      .r0_a(r0_a), .r0_b(r0_b), .r0_rsp_ready(r0_rsp_ready),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_sel(r1_sel),
      .r1_a(r1_a), .r1_b(r1_b), .r1_rsp_ready(r1_rsp_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared ALU model. Compare codes only drive bit 0 meaningfully.
   function automatic logic [31:0] tb_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] sel, input logic [31:0] g);
      case (sel)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << b[4:0];
         4'd6: return a >> b[4:0];
         4'd7: return ~a;
         4'd8: return {g[31:1], ($signed(a) < $signed(b))};
         4'd9: return {g[31:1], (a < b)};
         default: return a ^ b ^ 32'h5A5A5A5A;
      endcase
   endfunction

   assign alu_out = tb_alu(alu_a, alu_b, alu_sel, garb);

   // Expected response from the operation's meaning.
   function automatic logic [31:0] ref_data(input logic [3:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
      if (sel == 4'd8) return {31'b0, ($signed(a) < $signed(b))};
      if (sel == 4'd9) return {31'b0, (a < b)};
      if (sel >= 4'd10 && sel <= 4'd13) return 32'h0;
      return tb_alu(a, b, sel, 32'h0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // One full operation starting from IDLE at posedge+1; returns at posedge+1 in IDLE.
   task automatic transact(input bit v0, input bit v1,
                           input logic [3:0] s0, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [3:0] s1, input logic [31:0] a1, input logic [31:0] b1,
                           input int hold, input bit eid,
                           input logic [31:0] edata, input bit eerr);
      r0_valid = v0; r0_sel = s0; r0_a = a0; r0_b = b0;
      r1_valid = v1; r1_sel = s1; r1_a = a1; r1_b = b1;
      r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
      @(negedge clk);
      chk("grant", {30'b0, r1_ready, r0_ready}, eid ? 32'd2 : 32'd1);
      chk("busy_idle", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("exec_ready", {30'b0, r1_ready, r0_ready}, 32'd0);
      chk("exec_busy", {31'b0, busy}, 32'd1);
      chk("exec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("alu_a", alu_a, eid ? a1 : a0);
      chk("alu_b", alu_b, eid ? b1 : b0);
      chk("alu_sel", {28'b0, alu_sel}, {28'b0, (eid ? s1 : s0)});
      @(posedge clk); #1;
      for (int h = 0; h <= hold; h++) begin
         // The other requester's rsp_ready is asserted throughout and must be ignored.
         r0_rsp_ready = eid ? 1'b1 : (h == hold);
         r1_rsp_ready = eid ? (h == hold) : 1'b1;
         @(negedge clk);
         chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
         chk("rsp_id", {31'b0, rsp_id}, {31'b0, eid});
         chk("rsp_data", rsp_data, edata);
         chk("rsp_err", {31'b0, rsp_err}, {31'b0, eerr});
         chk("resp_ready", {30'b0, r1_ready, r0_ready}, 32'd0);
         chk("resp_busy", {31'b0, busy}, 32'd1);
         @(posedge clk); #1;
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
      r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
      @(negedge clk);
      chk("done_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("done_busy", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      m_last = eid;
   endtask

   typedef struct {
      bit          id;
      logic [3:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      int          hold;
      logic [31:0] exp_data;
      bit          exp_err;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; failures = 0; m_last = 1'b1;
      garb = 32'hDEADBEEF;
      r0_valid = 0; r0_sel = 0; r0_a = 0; r0_b = 0; r0_rsp_ready = 0;
      r1_valid = 0; r1_sel = 0; r1_a = 0; r1_b = 0; r1_rsp_ready = 0;

      vecs[0]  = '{1'b0, 4'b0000, 32'd5,        32'd3,      0, 32'd8,        1'b0};
      vecs[1]  = '{1'b1, 4'b1000, 32'hFFFFFFFF, 32'd1,      0, 32'h1,        1'b0};
      vecs[2]  = '{1'b0, 4'b1011, 32'd7,        32'd9,      1, 32'h0,        1'b1};
      vecs[3]  = '{1'b0, 4'b0010, 32'h0000F0F0, 32'h0000FF00, 0, 32'h0000F000, 1'b0};
      vecs[4]  = '{1'b1, 4'b1001, 32'hFFFFFFFF, 32'd1,      0, 32'h0,        1'b0};
      vecs[5]  = '{1'b1, 4'b0001, 32'd5,        32'd7,      4, 32'hFFFFFFFE, 1'b0};
      vecs[6]  = '{1'b0, 4'b1010, 32'd1,        32'd2,      0, 32'h0,        1'b1};
      vecs[7]  = '{1'b1, 4'b1101, 32'd3,        32'd3,      2, 32'h0,        1'b1};
      vecs[8]  = '{1'b0, 4'b0101, 32'd1,        32'd4,      0, 32'h10,       1'b0};
      vecs[9]  = '{1'b1, 4'b1110, 32'd0,        32'd0,      0, 32'h5A5A5A5A, 1'b0};
      vecs[10] = '{1'b0, 4'b1100, 32'd0,        32'd0,      0, 32'h0,        1'b1};
      vecs[11] = '{1'b1, 4'b0111, 32'd0,        32'd0,      0, 32'hFFFFFFFF, 1'b0};

      // Reset state, with both requesters pushing during reset.
      rst = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {30'b0, r1_ready, r0_ready}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_sel", {28'b0, alu_sel}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;

      // Tie-breaking alternates starting with requester 0.
      for (int k = 0; k < 4; k++) begin
         transact(1'b1, 1'b1, 4'd0, 32'd10, 32'd1, 4'd0, 32'd20, 32'd2, k % 2,
                  !m_last, m_last ? 32'd11 : 32'd22, 1'b0);
      end

      // Fixed single-requester vectors.
      for (int i = 0; i < 12; i++) begin
         transact(!vecs[i].id, vecs[i].id, vecs[i].sel, vecs[i].a, vecs[i].b,
                  vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].hold,
                  vecs[i].id, vecs[i].exp_data, vecs[i].exp_err);
      end

      // Randomized traffic against the request-level model.
      for (int n = 0; n < 150; n++) begin
         bit          v0, v1, eid;
         logic [3:0]  s0, s1;
         logic [31:0] a0, b0, a1, b1;
         v0 = 1'($urandom); v1 = 1'($urandom);
         s0 = 4'($urandom); s1 = 4'($urandom);
         a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
         if ($urandom_range(0, 1) == 0) begin
            a0 = $urandom_range(0, 7); b0 = $urandom_range(0, 7);
            a1 = $urandom_range(0, 7); b1 = $urandom_range(0, 7);
         end
         garb = $urandom;
         if (!v0 && !v1) begin
            @(negedge clk);
            chk("rand_idle_ready", {30'b0, r1_ready, r0_ready}, 32'd0);
            @(posedge clk); #1;
         end else begin
            eid = (v0 && v1) ? !m_last : v1;
            transact(v0, v1, s0, a0, b0, s1, a1, b1, $urandom_range(0, 3), eid,
                     eid ? ref_data(s1, a1, b1) : ref_data(s0, a0, b0),
                     eid ? (s1 >= 4'd10 && s1 <= 4'd13) : (s0 >= 4'd10 && s0 <= 4'd13));
         end
      end

      // Reset during RESP discards the response.
      r1_valid = 1'b1; r1_sel = 4'd0; r1_a = 32'd1; r1_b = 32'd1;
      @(negedge clk);
      chk("rr_grant", {30'b0, r1_ready, r0_ready}, 32'd2);
      @(posedge clk); #1;
      r1_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rr_rsp_valid_pre", {31'b0, rsp_valid}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
         chk("rr_busy", {31'b0, busy}, 32'd0);
         @(posedge clk); #1;
      end
      m_last = 1'b1;

      // Reset during EXEC: requester 0 wins, reset restores the pointer to 1.
      r0_valid = 1'b1; r0_sel = 4'd3; r0_a = 32'h55; r0_b = 32'hAA;
      @(negedge clk);
      chk("re_grant", {30'b0, r1_ready, r0_ready}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
      @(negedge clk);
      chk("re_rst_ready", {30'b0, r1_ready, r0_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
      @(negedge clk);
      chk("re_busy", {31'b0, busy}, 32'd0);
      chk("re_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("re_alu_sel", {28'b0, alu_sel}, 32'd0);
      @(posedge clk); #1;
      m_last = 1'b1;
      transact(1'b1, 1'b1, 4'd0, 32'd2, 32'd2, 4'd0, 32'd9, 32'd9, 0, 1'b0, 32'd4, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
